// File: rtl/ftg_pkg.sv
// ----------------------------------------------------------------------------
// ftg_pkg
// Shared types and constants for the frame timing generator (camera sensor
// emulator).
//   - ftg_state_e     : timing FSM states (IDLE, LEAD, LINE, HBLANK, VBLANK)
//   - FTG_DW_DEFAULT  : default pixel data width
//   - ftg_bayer_e     : Bayer colour selected by {row[0], col[0]}
//   - BAR_R/G/B       : 8-entry colour-bar level table, present only when
//                       FTG_COLOR_BAR_EN is defined
// Configuration macro: FTG_COLOR_BAR_EN (colour-bar pattern instead of ramp).
// ----------------------------------------------------------------------------
package ftg_pkg;

    localparam int FTG_DW_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } ftg_state_e;

    // Bayer mosaic: even rows are G/R, odd rows are B/G.
    typedef enum logic [1:0] {
        BAYER_G0 = 2'b00,
        BAYER_R  = 2'b01,
        BAYER_B  = 2'b10,
        BAYER_G1 = 2'b11
    } ftg_bayer_e;

`ifdef FTG_COLOR_BAR_EN
    localparam int FTG_NUM_BARS = 8;

    typedef logic [FTG_DW_DEFAULT-1:0] ftg_level_t;

    // 75% colour bars: white, yellow, cyan, green, magenta, red, blue, black.
    localparam ftg_level_t BAR_R [FTG_NUM_BARS] = '{
        12'hBFF, 12'hBFF, 12'h040, 12'h040, 12'hBFF, 12'hBFF, 12'h040, 12'h040
    };
    localparam ftg_level_t BAR_G [FTG_NUM_BARS] = '{
        12'hBFF, 12'hBFF, 12'hBFF, 12'hBFF, 12'h040, 12'h040, 12'h040, 12'h040
    };
    localparam ftg_level_t BAR_B [FTG_NUM_BARS] = '{
        12'hBFF, 12'h040, 12'hBFF, 12'h040, 12'hBFF, 12'h040, 12'hBFF, 12'h040
    };
`endif

endpackage

// File: rtl/ftg_pattern.sv
// ----------------------------------------------------------------------------
// ftg_pattern
// Maps a pixel position to the pixel value and registers it, so oDATA lines up
// with the registered FVAL/LVAL/X/Y of the timing generator. The inputs are the
// timing generator's next-state values for that reason.
//   clk_i   : pixel clock
//   rst_ni  : synchronous active-low reset
//   x_i     : next pixel column
//   y_i     : next line index
//   lval_i  : next line-valid; data is forced to 0 outside active pixels
//   data_o  : registered pixel data
// Configuration macro: FTG_COLOR_BAR_EN selects the Bayer colour-bar pattern;
// otherwise the pattern is the linear ramp y*H_ACTIVE + x truncated to DW.
// ----------------------------------------------------------------------------
module ftg_pattern
    import ftg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int DW       = FTG_DW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [15:0]   x_i,
    input  logic [15:0]   y_i,
    input  logic          lval_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

`ifdef FTG_COLOR_BAR_EN
    logic [2:0]  bar;
    ftg_bayer_e  sel;

    // The line is cut into 8 equal bars; within a bar the Bayer position picks
    // which colour channel's level is emitted.
    always_comb begin
        data_d = '0;
        bar    = 3'((32'(x_i) * 32'd8) / 32'(H_ACTIVE));
        sel    = ftg_bayer_e'({y_i[0], x_i[0]});
        if (lval_i) begin
            case (sel)
                BAYER_R: data_d = DW'(BAR_R[bar]);
                BAYER_B: data_d = DW'(BAR_B[bar]);
                default: data_d = DW'(BAR_G[bar]);
            endcase
        end
    end
`else
    // Ramp: each active pixel gets its raster index, wrapping silently at DW bits.
    always_comb begin
        data_d = '0;
        if (lval_i) begin
            data_d = DW'(32'(y_i) * 32'(H_ACTIVE) + 32'(x_i));
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/frame_timing_gen.sv
// ----------------------------------------------------------------------------
// frame_timing_gen
// Emulates a CMOS sensor's FVAL/LVAL/DATA timing so the capture path can run
// without a physical camera. Frames are produced back to back while iEN is
// high; iEN is only looked at in IDLE and at the end of vertical blanking, so
// a frame in progress always completes.
//   iCLK        : pixel clock
//   iRST_N      : synchronous active-low reset (aborts any frame at once)
//   iEN         : frame generation enable
//   oFVAL       : frame valid
//   oLVAL       : line valid
//   oDATA       : pixel data, 0 whenever oLVAL is low
//   oX          : pixel column in the current line
//   oY          : line index in the current frame
//   oFrame_Cnt  : completed frames, wraps 0xFFFF -> 0
//   oFrame_Done : one-cycle pulse on the first cycle FVAL is low after a frame
// Configuration macro: FTG_COLOR_BAR_EN (colour-bar data instead of ramp;
// timing is identical in both builds).
// ----------------------------------------------------------------------------
module frame_timing_gen
    import ftg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 64,
    parameter int FV_LEAD  = 4,
    parameter int DW       = FTG_DW_DEFAULT
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iEN,
    output logic          oFVAL,
    output logic          oLVAL,
    output logic [DW-1:0] oDATA,
    output logic [15:0]   oX,
    output logic [15:0]   oY,
    output logic [15:0]   oFrame_Cnt,
    output logic          oFrame_Done
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    // One phase counter serves LEAD, HBLANK and VBLANK, so it is sized for
    // the longest of the three.
    localparam int PMAX = (FV_LEAD > H_BLANK)
                        ? ((FV_LEAD > V_BLANK) ? FV_LEAD : V_BLANK)
                        : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    ftg_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   frameCnt_q, frameCnt_d;
    logic          done_q, done_d;
    logic          fval_q, fval_d;
    logic          lval_q, lval_d;

    // Next-state logic. The counters advance together with the state so that
    // every registered output shows the state entered on the same edge.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        x_d        = x_q;
        y_d        = y_q;
        frameCnt_d = frameCnt_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (iEN) begin
                    state_d = LEAD;
                    phase_d = '0;
                end
            end
            LEAD: begin
                if (phase_q == PW'(FV_LEAD - 1)) begin
                    state_d = LINE;
                    x_d     = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LINE: begin
                if (x_q == XW'(H_ACTIVE - 1)) begin
                    x_d     = '0;
                    phase_d = '0;
                    if (y_q < YW'(V_ACTIVE - 1)) begin
                        state_d = HBLANK;
                    end else begin
                        // Frame is complete: the first VBLANK cycle carries the
                        // Done pulse and the updated frame count.
                        state_d    = VBLANK;
                        done_d     = 1'b1;
                        frameCnt_d = frameCnt_q + 16'd1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            HBLANK: begin
                if (phase_q == PW'(H_BLANK - 1)) begin
                    state_d = LINE;
                    y_d     = y_q + 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            VBLANK: begin
                if (phase_q == PW'(V_BLANK - 1)) begin
                    y_d     = '0;
                    phase_d = '0;
                    state_d = iEN ? LEAD : IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        fval_d = (state_d == LEAD) || (state_d == LINE) || (state_d == HBLANK);
        lval_d = (state_d == LINE);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frameCnt_q <= '0;
            done_q     <= 1'b0;
            fval_q     <= 1'b0;
            lval_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frameCnt_q <= frameCnt_d;
            done_q     <= done_d;
            fval_q     <= fval_d;
            lval_q     <= lval_d;
        end
    end

    // The pattern stage registers its output, so it is fed next-state values.
    ftg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .DW       (DW)
    ) uPattern (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .x_i    (16'(x_d)),
        .y_i    (16'(y_d)),
        .lval_i (lval_d),
        .data_o (oDATA)
    );

    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oX          = 16'(x_q);
    assign oY          = 16'(y_q);
    assign oFrame_Cnt  = frameCnt_q;
    assign oFrame_Done = done_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_frame_timing_gen
// Self-checking bench for frame_timing_gen with small timing parameters.
// The reference model tracks only "generating or idle" and the cycle position
// inside the frame period; every output is derived from that position with
// plain arithmetic.
// ----------------------------------------------------------------------------
module tb_frame_timing_gen;
    import ftg_pkg::*;

    localparam int HA     = 4;
    localparam int HB     = 2;
    localparam int VA     = 3;
    localparam int VB     = 5;
    localparam int FL     = 1;
    localparam int DW     = 12;
    localparam int SPAN   = FL + VA * HA + (VA - 1) * HB;
    localparam int PERIOD = SPAN + VB;

    logic          clk  = 1'b0;
    logic          rstN = 1'b0;
    logic          en   = 1'b0;
    logic          oFVAL;
    logic          oLVAL;
    logic [DW-1:0] oDATA;
    logic [15:0]   oX;
    logic [15:0]   oY;
    logic [15:0]   oFrame_Cnt;
    logic          oFrame_Done;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit mActive = 1'b0;
    int mPos    = 0;
    int mCnt    = 0;

    always #5 clk = ~clk;

    frame_timing_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .FV_LEAD  (FL),
        .DW       (DW)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rstN),
        .iEN         (en),
        .oFVAL       (oFVAL),
        .oLVAL       (oLVAL),
        .oDATA       (oDATA),
        .oX          (oX),
        .oY          (oY),
        .oFrame_Cnt  (oFrame_Cnt),
        .oFrame_Done (oFrame_Done)
    );

    // Expected pixel value for an active pixel.
    function automatic logic [DW-1:0] expData(input int x, input int y);
`ifdef FTG_COLOR_BAR_EN
        int bar;
        bar = (x * 8) / HA;
        if ((y % 2) == 0 && (x % 2) == 1) return DW'(BAR_R[bar]);
        if ((y % 2) == 1 && (x % 2) == 0) return DW'(BAR_B[bar]);
        return DW'(BAR_G[bar]);
`else
        return DW'(y * HA + x);
`endif
    endfunction

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelStep(input logic r, input logic e);
        if (!r) begin
            mActive = 1'b0;
            mPos    = 0;
            mCnt    = 0;
        end else if (!mActive) begin
            if (e) begin
                mActive = 1'b1;
                mPos    = 0;
            end
        end else if (mPos == PERIOD - 1) begin
            mPos = 0;
            if (!e) mActive = 1'b0;
        end else begin
            mPos = mPos + 1;
            if (mPos == SPAN) mCnt = (mCnt + 1) % 65536;
        end
    endtask

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model's view of the current cycle.
    task automatic checkOutput();
        int eF, eL, eX, eY, eDone, q, r;
        logic [DW-1:0] eDat;
        eF = 0; eL = 0; eX = 0; eY = 0; eDone = 0;
        if (mActive) begin
            eF    = (mPos < SPAN) ? 1 : 0;
            eDone = (mPos == SPAN) ? 1 : 0;
            if (mPos >= FL && mPos < SPAN) begin
                q  = mPos - FL;
                eY = q / (HA + HB);
                r  = q % (HA + HB);
                if (r < HA) begin
                    eL = 1;
                    eX = r;
                end
            end else if (mPos >= SPAN) begin
                eY = VA - 1;
            end
        end
        eDat = (eL != 0) ? expData(eX, eY) : '0;
        checkField("fval",  32'(oFVAL),       32'(eF));
        checkField("lval",  32'(oLVAL),       32'(eL));
        checkField("x",     32'(oX),          32'(eX));
        checkField("y",     32'(oY),          32'(eY));
        checkField("done",  32'(oFrame_Done), 32'(eDone));
        checkField("count", 32'(oFrame_Cnt),  32'(mCnt));
        checkField("data",  32'(oDATA),       32'(eDat));
    endtask

    task automatic applyStimulus(input logic r, input logic e);
        rstN = r;
        en   = e;
        @(posedge clk);
        modelStep(r, e);
        #1;
        checkOutput();
    endtask

    initial begin
        int fvHigh;
        int lvRise;
        int doneSeen;
        logic prevL;
        logic rndR;
        logic rndE;

        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("[TB] basic timing and ramp data");
        fvHigh = 0;
        lvRise = 0;
        prevL  = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b1, 1'b1);
            fvHigh += int'(oFVAL);
            if (oLVAL && !prevL) lvRise++;
            prevL = oLVAL;
        end
        checkField("fval_span", 32'(fvHigh), 32'(SPAN));
        checkField("lval_pulses", 32'(lvRise), 32'(VA));
        applyStimulus(1'b1, 1'b1);
        checkField("fval_restart", 32'(oFVAL), 32'd1);

        $display("[TB] enable drop mid-frame");
        repeat (FL + HA + HB) applyStimulus(1'b1, 1'b1);
        doneSeen = 0;
        fvHigh   = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0);
            doneSeen += int'(oFrame_Done);
        end
        checkField("drop_done_pulses", 32'(doneSeen), 32'd1);
        checkField("drop_frame_cnt", 32'(oFrame_Cnt), 32'd2);
        checkField("drop_idle_fval", 32'(oFVAL), 32'd0);

        $display("[TB] reset mid-line");
        applyStimulus(1'b1, 1'b1);
        repeat (FL + 2 * (HA + HB) + 1) applyStimulus(1'b1, 1'b1);
        checkField("pre_reset_lval", 32'(oLVAL), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkField("reset_frame_cnt", 32'(oFrame_Cnt), 32'd0);
        checkField("reset_fval", 32'(oFVAL), 32'd0);
        fvHigh = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b1, 1'b1);
            fvHigh += int'(oFVAL);
        end
        checkField("post_reset_span", 32'(fvHigh), 32'(SPAN));

        $display("[TB] randomized run");
        rndE = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rndR = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) rndE = ~rndE;
            applyStimulus(rndR, rndE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
